// File: rtl/wb_pattern_master.sv
// Wishbone classic master: writes SEED+i over NWORDS words from BASE, reads back, counts mismatches.
// Latency: each transfer is its ack cycle plus one idle gap, so done arrives 4*NWORDS+1 cycles after start at the earliest.
// Backpressure: bus outputs hold until wb_ack_i; a transfer is abandoned after TIMEOUT unacked strobe cycles.
module wb_pattern_master #(
  parameter int unsigned   AW      = 16,
  parameter int unsigned   DW      = 16,
  parameter logic [AW-1:0] BASE    = '0,
  parameter int unsigned   NWORDS  = 16,
  parameter logic [DW-1:0] SEED    = 16'hA5A0,
  parameter int unsigned   TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [15:0]   err_count,
  output logic [AW-1:0] fail_adr
);

  localparam logic [AW-1:0] LAST = AW'(NWORDS - 1);
  localparam logic [15:0]   TLIM = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WGAP, S_RD, S_RGAP, S_DONE} state_t;

  state_t        state;
  logic [AW-1:0] idx;
  logic [AW-1:0] idx_inc;
  logic [AW-1:0] adr_nxt;
  logic [DW-1:0] pat;
  logic [DW-1:0] pat_nxt;
  logic [15:0]   tcnt;

  // Address arithmetic wraps naturally at 2^AW, pattern at 2^DW.
  assign idx_inc = idx + AW'(1);
  assign adr_nxt = BASE + idx_inc;
  assign pat     = SEED + DW'(idx);
  assign pat_nxt = SEED + DW'(idx_inc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      tcnt      <= '0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      err_count <= '0;
      fail_adr  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            err_count <= '0;
            fail_adr  <= '0;
            timeout   <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            idx       <= '0;
            tcnt      <= '0;
            wb_cyc_o  <= 1'b1;
            wb_stb_o  <= 1'b1;
            wb_we_o   <= 1'b1;
            wb_adr_o  <= BASE;
            wb_dat_o  <= SEED;
            state     <= S_WR;
          end
        end
        S_WR, S_RD: begin
          if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            state    <= (state == S_WR) ? S_WGAP : S_RGAP;
            if (state == S_RD && wb_dat_i != pat) begin
              if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
              if (err_count == 16'd0) fail_adr <= wb_adr_o;
            end
          end else if (tcnt == TLIM) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            timeout  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
            pass     <= 1'b0;
            state    <= S_DONE;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        S_WGAP: begin
          tcnt     <= '0;
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          if (idx == LAST) begin
            idx      <= '0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= BASE;
            wb_dat_o <= '0;
            state    <= S_RD;
          end else begin
            idx      <= idx_inc;
            wb_we_o  <= 1'b1;
            wb_adr_o <= adr_nxt;
            wb_dat_o <= pat_nxt;
            state    <= S_WR;
          end
        end
        S_RGAP: begin
          if (idx == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == 16'd0) && !timeout;
            state <= S_DONE;
          end else begin
            idx      <= idx_inc;
            tcnt     <= '0;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b0;
            wb_adr_o <= adr_nxt;
            wb_dat_o <= '0;
            state    <= S_RD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_pattern_master.sv
// Bench for wb_pattern_master: two instances (BASE 0 and BASE FFFE), each on a small configurable slave.
module tb_wb_pattern_master;

  localparam int TMO = 8;
  localparam int NW  = 4;
  localparam logic [15:0] SEED = 16'hA5A0;

  logic        clk;
  logic        rst    [2];
  logic        start  [2];
  logic        cyc    [2];
  logic        stb    [2];
  logic        we     [2];
  logic        ack    [2];
  logic        busy   [2];
  logic        done   [2];
  logic        pass   [2];
  logic        tmo    [2];
  logic [15:0] adr    [2];
  logic [15:0] dato   [2];
  logic [15:0] dati   [2];
  logic [15:0] errc   [2];
  logic [15:0] fadr   [2];

  // slave configuration and storage
  int          ws      [2];
  bit          noack   [2];
  int          bad_adr [2];
  int          wcnt    [2];
  logic [15:0] mem     [2][16];

  // reference model of the expected transfer sequence
  logic [15:0] base_k  [2];
  logic [15:0] eadr    [2][8];
  logic [15:0] edat    [2][8];
  bit          ewe     [2][8];
  int          ptr     [2];
  int          nx      [2];
  int          m_err   [2];
  logic [15:0] m_fail  [2];
  bit          m_to    [2];
  int          m_wait  [2];
  bit          prev_ack[2];
  int          stb_cycles[2];

  int checks;
  int failures;

  wb_pattern_master #(.AW(16), .DW(16), .BASE(16'h0000), .NWORDS(NW), .SEED(SEED), .TIMEOUT(TMO)) dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]),
    .wb_cyc_o(cyc[0]), .wb_stb_o(stb[0]), .wb_we_o(we[0]), .wb_adr_o(adr[0]), .wb_dat_o(dato[0]),
    .wb_dat_i(dati[0]), .wb_ack_i(ack[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .timeout(tmo[0]),
    .err_count(errc[0]), .fail_adr(fadr[0])
  );

  wb_pattern_master #(.AW(16), .DW(16), .BASE(16'hFFFE), .NWORDS(NW), .SEED(SEED), .TIMEOUT(TMO)) dut1 (
    .clk(clk), .rst(rst[1]), .start(start[1]),
    .wb_cyc_o(cyc[1]), .wb_stb_o(stb[1]), .wb_we_o(we[1]), .wb_adr_o(adr[1]), .wb_dat_o(dato[1]),
    .wb_dat_i(dati[1]), .wb_ack_i(ack[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .timeout(tmo[1]),
    .err_count(errc[1]), .fail_adr(fadr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      ack[k]  = cyc[k] && stb[k] && !noack[k] && (wcnt[k] == ws[k]);
      dati[k] = 16'hDEAD;
      if (ack[k] && !we[k])
        dati[k] = (int'(adr[k]) == bad_adr[k]) ? 16'h0000 : mem[k][adr[k][3:0]];
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (cyc[k] && stb[k] && !ack[k]) wcnt[k] <= wcnt[k] + 1;
      else wcnt[k] <= 0;
      if (ack[k] && we[k]) mem[k][adr[k][3:0]] <= dato[k];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic arm(input int k);
    for (int i = 0; i < NW; i++) begin
      eadr[k][i]      = 16'(base_k[k] + 16'(i));
      edat[k][i]      = 16'(SEED + 16'(i));
      ewe[k][i]       = 1'b1;
      eadr[k][NW + i] = 16'(base_k[k] + 16'(i));
      edat[k][NW + i] = 16'(SEED + 16'(i));
      ewe[k][NW + i]  = 1'b0;
    end
    ptr[k] = 0; nx[k] = 2 * NW; m_err[k] = 0; m_fail[k] = 16'h0;
    m_to[k] = 1'b0; m_wait[k] = 0; stb_cycles[k] = 0;
  endtask

  // Every-cycle comparison of bus behaviour against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        prev_ack[k] = 1'b0;
      end else begin
        chk("stb_eq_cyc", 32'(stb[k]), 32'(cyc[k]));
        if (!cyc[k]) chk("idle_adr", 32'(adr[k]), 32'h0);
        if (!we[k])  chk("rd_dat_o_zero", 32'(dato[k]), 32'h0);
        if (prev_ack[k]) chk("gap_after_ack", 32'(cyc[k]), 32'h0);
        if (stb[k]) begin
          stb_cycles[k]++;
          if (ptr[k] >= nx[k]) begin
            chk("extra_stb", 32'(stb[k]), 32'h0);
          end else begin
            chk("xfer_adr", 32'(adr[k]), 32'(eadr[k][ptr[k]]));
            chk("xfer_we", 32'(we[k]), 32'(ewe[k][ptr[k]]));
            if (ewe[k][ptr[k]]) chk("xfer_wdat", 32'(dato[k]), 32'(edat[k][ptr[k]]));
            if (ack[k]) begin
              if (!we[k] && dati[k] != edat[k][ptr[k]]) begin
                m_err[k]++;
                if (m_err[k] == 1) m_fail[k] = eadr[k][ptr[k]];
              end
              ptr[k]++;
              m_wait[k] = 0;
            end else begin
              m_wait[k]++;
              if (m_wait[k] == TMO) begin
                m_to[k] = 1'b1;
                nx[k]   = ptr[k];
              end
            end
          end
        end
        prev_ack[k] = cyc[k] && stb[k] && ack[k];
      end
    end
  end

  task automatic run(input int k, input int lat, input int pulse_at);
    int cnt;
    cnt = 0;
    @(negedge clk);
    start[k] = 1'b1;
    arm(k);
    do begin
      @(negedge clk);
      cnt++;
      start[k] = (cnt == pulse_at);
    end while (!done[k] && cnt < 400);
    start[k] = 1'b0;
    chk("done_seen", 32'(done[k]), 32'h1);
    if (lat > 0) chk("latency", 32'(cnt), 32'(lat));
    chk("busy_end", 32'(busy[k]), 32'h0);
    chk("err_count", 32'(errc[k]), 32'(m_err[k]));
    chk("fail_adr", 32'(fadr[k]), 32'(m_fail[k]));
    chk("timeout", 32'(tmo[k]), 32'(m_to[k]));
    chk("pass", 32'(pass[k]), 32'((m_err[k] == 0) && !m_to[k]));
    chk("all_xfers", 32'(ptr[k]), 32'(nx[k]));
  endtask

  initial begin
    checks = 0; failures = 0;
    base_k[0] = 16'h0000; base_k[1] = 16'hFFFE;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; start[k] = 1'b0; ws[k] = 0; noack[k] = 1'b0; bad_adr[k] = -1;
      ptr[k] = 0; nx[k] = 0; m_err[k] = 0; m_fail[k] = 16'h0; m_to[k] = 1'b0;
      m_wait[k] = 0; prev_ack[k] = 1'b0; stb_cycles[k] = 0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_cyc", 32'(cyc[k]), 32'h0);
      chk("rst_busy", 32'(busy[k]), 32'h0);
      chk("rst_done", 32'(done[k]), 32'h0);
      chk("rst_pass", 32'(pass[k]), 32'h0);
      chk("rst_err", 32'(errc[k]), 32'h0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;

    // zero-wait slave, full run
    run(0, 17, -1);
    chk("t1_pass_lit", 32'(pass[0]), 32'h1);
    chk("t1_err_lit", 32'(errc[0]), 32'h0);
    repeat (5) @(negedge clk);
    chk("t1_done_hold", 32'(done[0]), 32'h1);
    chk("t1_pass_hold", 32'(pass[0]), 32'h1);

    // corrupted read of address 2
    bad_adr[0] = 2;
    run(0, 17, -1);
    chk("t2_err_lit", 32'(errc[0]), 32'h1);
    chk("t2_fadr_lit", 32'(fadr[0]), 32'h2);
    chk("t2_pass_lit", 32'(pass[0]), 32'h0);
    bad_adr[0] = -1;

    // slave never acknowledges
    noack[0] = 1'b1;
    run(0, -1, -1);
    chk("t3_tmo_lit", 32'(tmo[0]), 32'h1);
    chk("t3_pass_lit", 32'(pass[0]), 32'h0);
    chk("t3_stb_cycles", 32'(stb_cycles[0]), 32'd8);
    repeat (20) @(negedge clk);
    chk("t3_no_more_stb", 32'(stb_cycles[0]), 32'd8);
    chk("t3_done_hold", 32'(done[0]), 32'h1);
    noack[0] = 1'b0;

    // address window wrapping past FFFF
    run(1, 17, -1);
    chk("t4_pass_lit", 32'(pass[1]), 32'h1);
    chk("t4_mem_fffe", 32'(mem[1][14]), 32'hA5A0);
    chk("t4_mem_0000", 32'(mem[1][0]), 32'hA5A2);
    chk("t4_mem_0001", 32'(mem[1][1]), 32'hA5A3);

    // reset during a read strobe
    ws[0] = 3;
    @(negedge clk);
    start[0] = 1'b1;
    arm(0);
    @(negedge clk);
    start[0] = 1'b0;
    begin
      int guard;
      guard = 0;
      while (!(stb[0] && !we[0]) && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      chk("t5_reached_rd", 32'(stb[0] && !we[0]), 32'h1);
    end
    rst[0] = 1'b1;
    @(negedge clk);
    chk("t5_cyc", 32'(cyc[0]), 32'h0);
    chk("t5_stb", 32'(stb[0]), 32'h0);
    chk("t5_busy", 32'(busy[0]), 32'h0);
    chk("t5_done", 32'(done[0]), 32'h0);
    chk("t5_adr", 32'(adr[0]), 32'h0);
    nx[0] = 0;
    rst[0] = 1'b0;
    run(0, 41, -1);
    chk("t5_pass_lit", 32'(pass[0]), 32'h1);

    // three wait states, start pulsed mid-run
    run(0, 41, 10);
    chk("t6_pass_lit", 32'(pass[0]), 32'h1);
    chk("t6_stb_cycles", 32'(stb_cycles[0]), 32'd32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
